axi_master_cmd: RTL

- Single-outstanding AXI4 (Lite-subset) master sitting directly upstream of the team's 4-register AXI slave.
- Converts a simple valid/ready command stream (read or write, one beat) into AXI AW/W/B or AR/R transactions.
- Returns the result on a valid/ready response stream.
- Used by test sequencers and control FSMs to program the register block.

---
 rtl/axi_master_cmd.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_master_cmd.sv
// axi_master_cmd
//   Single-outstanding AXI4-Lite master. Takes one-beat read/write commands
//   on a valid/ready stream, runs them as AW/W/B or AR/R transactions, and
//   hands back the slave's response on a valid/ready response stream.
//
// Ports
//   aclk, areset         clock and synchronous active-high reset
//   cmd_*                command stream (valid/ready, write flag, addr, data, strobes)
//   rsp_*                response stream (valid/ready, write echo, read data, resp code)
//   busy                 high whenever a command is in flight
//   m_axi_*              AXI4-Lite master interface (AW, W, B, AR, R channels)
//
// Every output is driven from a register, so there are no combinational
// paths from AXI inputs to AXI outputs. cmd_ready is decoded straight from
// the state register.
module axi_master_cmd #(
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter logic [2:0]  C_AXPROT           = 3'b000
) (
  input  logic                            aclk,
  input  logic                            areset,

  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,

  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic                            rsp_write,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,

  output logic                            busy,

  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]                      m_axi_awprot,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,
  input  logic [1:0]                      m_axi_bresp,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]                      m_axi_arprot,
  output logic                            m_axi_arvalid,
  input  logic                            m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                      m_axi_rresp,
  input  logic                            m_axi_rvalid,
  output logic                            m_axi_rready
);

  localparam int unsigned STRB_W = C_M_AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_RSP
  } state_t;

  state_t                        state_reg,     state_next;
  logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr_reg,    awaddr_next;
  logic [C_M_AXI_ADDR_WIDTH-1:0] araddr_reg,    araddr_next;
  logic [C_M_AXI_DATA_WIDTH-1:0] wdata_reg,     wdata_next;
  logic [STRB_W-1:0]             wstrb_reg,     wstrb_next;
  logic                          awvalid_reg,   awvalid_next;
  logic                          wvalid_reg,    wvalid_next;
  logic                          bready_reg,    bready_next;
  logic                          arvalid_reg,   arvalid_next;
  logic                          rready_reg,    rready_next;
  logic                          rsp_valid_reg, rsp_valid_next;
  logic                          rsp_write_reg, rsp_write_next;
  logic [C_M_AXI_DATA_WIDTH-1:0] rsp_rdata_reg, rsp_rdata_next;
  logic [1:0]                    rsp_resp_reg,  rsp_resp_next;
  logic                          busy_reg,      busy_next;

  // A channel is still waiting if its valid is up and the slave is not
  // taking it on this edge. AW and W retire independently.
  logic aw_waiting;
  logic w_waiting;
  assign aw_waiting = awvalid_reg && !m_axi_awready;
  assign w_waiting  = wvalid_reg  && !m_axi_wready;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_reg     <= ST_IDLE;
      awaddr_reg    <= '0;
      araddr_reg    <= '0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      awvalid_reg   <= 1'b0;
      wvalid_reg    <= 1'b0;
      bready_reg    <= 1'b0;
      arvalid_reg   <= 1'b0;
      rready_reg    <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_write_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_resp_reg  <= 2'b00;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      awaddr_reg    <= awaddr_next;
      araddr_reg    <= araddr_next;
      wdata_reg     <= wdata_next;
      wstrb_reg     <= wstrb_next;
      awvalid_reg   <= awvalid_next;
      wvalid_reg    <= wvalid_next;
      bready_reg    <= bready_next;
      arvalid_reg   <= arvalid_next;
      rready_reg    <= rready_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_write_reg <= rsp_write_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_resp_reg  <= rsp_resp_next;
      busy_reg      <= busy_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    awaddr_next    = awaddr_reg;
    araddr_next    = araddr_reg;
    wdata_next     = wdata_reg;
    wstrb_next     = wstrb_reg;
    awvalid_next   = awvalid_reg;
    wvalid_next    = wvalid_reg;
    bready_next    = bready_reg;
    arvalid_next   = arvalid_reg;
    rready_next    = rready_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_write_next = rsp_write_reg;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_resp_next  = rsp_resp_reg;

    case (state_reg)
      ST_IDLE: begin
        // cmd_ready is implied in this state.
        if (cmd_valid) begin
          if (cmd_write) begin
            awaddr_next  = cmd_addr;
            wdata_next   = cmd_wdata;
            wstrb_next   = cmd_wstrb;
            awvalid_next = 1'b1;
            wvalid_next  = 1'b1;
            state_next   = ST_WR;
          end else begin
            araddr_next  = cmd_addr;
            arvalid_next = 1'b1;
            state_next   = ST_RD_ADDR;
          end
        end
      end

      ST_WR: begin
        awvalid_next = aw_waiting;
        wvalid_next  = w_waiting;
        if (!aw_waiting && !w_waiting) begin
          bready_next = 1'b1;
          state_next  = ST_WR_RESP;
        end
      end

      ST_WR_RESP: begin
        if (m_axi_bvalid) begin
          bready_next    = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_write_next = 1'b1;
          rsp_rdata_next = '0;
          rsp_resp_next  = m_axi_bresp;
          state_next     = ST_RSP;
        end
      end

      ST_RD_ADDR: begin
        if (m_axi_arready) begin
          arvalid_next = 1'b0;
          rready_next  = 1'b1;
          state_next   = ST_RD_DATA;
        end
      end

      ST_RD_DATA: begin
        if (m_axi_rvalid) begin
          rready_next    = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_write_next = 1'b0;
          rsp_rdata_next = m_axi_rdata;
          rsp_resp_next  = m_axi_rresp;
          state_next     = ST_RSP;
        end
      end

      ST_RSP: begin
        // Return to IDLE only; the next command is taken a cycle later.
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    busy_next = (state_next != ST_IDLE);
  end

  assign cmd_ready     = (state_reg == ST_IDLE);
  assign busy          = busy_reg;

  assign rsp_valid     = rsp_valid_reg;
  assign rsp_write     = rsp_write_reg;
  assign rsp_rdata     = rsp_rdata_reg;
  assign rsp_resp      = rsp_resp_reg;

  assign m_axi_awaddr  = awaddr_reg;
  assign m_axi_awprot  = C_AXPROT;
  assign m_axi_awvalid = awvalid_reg;
  assign m_axi_wdata   = wdata_reg;
  assign m_axi_wstrb   = wstrb_reg;
  assign m_axi_wvalid  = wvalid_reg;
  assign m_axi_bready  = bready_reg;
  assign m_axi_araddr  = araddr_reg;
  assign m_axi_arprot  = C_AXPROT;
  assign m_axi_arvalid = arvalid_reg;
  assign m_axi_rready  = rready_reg;

endmodule
